// File: rtl/image_spi_master.sv
// image_spi_master
// Streams one image (NUM_PIXELS pixel bytes followed by a label byte) to an
// SPI digit recognizer, then polls its status byte until the ready bit is set
// and reads back a cost byte. SPI mode 0, MSB first, SCK idle low.
//
// Ports
//   clk            system clock
//   n_rst          synchronous active-low reset
//   start          one-cycle pulse, begins a transaction (accepted in IDLE only)
//   label[3:0]     expected digit, latched on accepted start
//   pix_data[7:0]  pixel byte, pix_valid/pix_ready handshake
//   pix_valid      pix_data valid
//   pix_ready      block accepts a pixel byte this cycle
//   SCK, SS, MOSI  SPI clock, active-low slave select, serial data out
//   MISO           serial data from recognizer
//   busy           transaction in progress
//   result_valid   one-cycle pulse, detected_digit/cost valid
//   detected_digit status[3:0] of the last successful poll
//   cost[7:0]      cost byte of the last successful transaction
//   timeout        one-cycle pulse, MAX_POLLS polls without ready
//
// state | meaning
// IDLE  | SS high, waiting for start
// LOAD  | pick next write byte: pixel (handshake) or label
// SHIFT | shift one write-phase byte
// GAP   | SS high for GAP_CYCLES before a status poll
// POLL  | shift 0x00 out, capture status byte
// COST  | shift 0x00 out, capture cost byte
// DONE  | one cycle, pulse result_valid or timeout

module image_spi_master #(
    parameter int CLK_DIV    = 4,
    parameter int NUM_PIXELS = 784,
    parameter int GAP_CYCLES = 16,
    parameter int MAX_POLLS  = 255
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic [3:0] label,
    input  logic [7:0] pix_data,
    input  logic       pix_valid,
    output logic       pix_ready,
    output logic       SCK,
    output logic       SS,
    output logic       MOSI,
    input  logic       MISO,
    output logic       busy,
    output logic       result_valid,
    output logic [3:0] detected_digit,
    output logic [7:0] cost,
    output logic       timeout
);

    localparam int CNT_W = $clog2(NUM_PIXELS + 2);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CNT_W-1:0] NPIX       = CNT_W'(NUM_PIXELS);
    localparam logic [DIV_W-1:0] DIV_LOAD   = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(GAP_CYCLES - 1);
    localparam logic [7:0]       POLL_LIMIT = 8'(MAX_POLLS);

    typedef enum logic [2:0] {
        IDLE, LOAD, SHIFT, GAP, POLL, COST, DONE
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  byte_cnt, byte_cnt_n;
    logic [7:0]        poll_cnt, poll_cnt_n;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;
    logic [DIV_W-1:0]  div_cnt, div_cnt_n;
    logic [2:0]        bit_cnt, bit_cnt_n;
    logic              sck_q, sck_n;
    logic              ss_q, ss_n;
    logic [7:0]        shreg, shreg_n;
    logic [7:0]        rx, rx_n;
    logic [3:0]        label_q, label_n;
    logic [3:0]        digit_q, digit_n;
    logic [7:0]        cost_q, cost_n;
    logic              tmo_q, tmo_n;

    logic              shift_active;
    logic              byte_end;
    logic              arm;
    logic [7:0]        poll_inc;

    assign shift_active = (state == SHIFT) || (state == POLL) || (state == COST);
    assign poll_inc     = poll_cnt + 8'd1;

    always_comb begin
        state_n      = state;
        byte_cnt_n   = byte_cnt;
        poll_cnt_n   = poll_cnt;
        gap_cnt_n    = gap_cnt;
        div_cnt_n    = div_cnt;
        bit_cnt_n    = bit_cnt;
        sck_n        = sck_q;
        ss_n         = ss_q;
        shreg_n      = shreg;
        rx_n         = rx;
        label_n      = label_q;
        digit_n      = digit_q;
        cost_n       = cost_q;
        tmo_n        = tmo_q;
        byte_end     = 1'b0;
        arm          = 1'b0;
        pix_ready    = 1'b0;
        result_valid = 1'b0;
        timeout      = 1'b0;

        // Bit engine: CLK_DIV low cycles then CLK_DIV high cycles per bit.
        // MISO is captured on the rising transition, MOSI advances on the
        // falling one, so the slave always sees stable data at its sample edge.
        if (shift_active) begin
            if (div_cnt != '0) begin
                div_cnt_n = div_cnt - 1'b1;
            end else begin
                div_cnt_n = DIV_LOAD;
                if (!sck_q) begin
                    sck_n = 1'b1;
                    rx_n  = {rx[6:0], MISO};
                end else begin
                    sck_n   = 1'b0;
                    shreg_n = {shreg[6:0], 1'b0};
                    if (bit_cnt == 3'd0) begin
                        byte_end = 1'b1;
                    end else begin
                        bit_cnt_n = bit_cnt - 3'd1;
                    end
                end
            end
        end

        case (state)
            IDLE: begin
                if (start) begin
                    label_n    = label;
                    ss_n       = 1'b0;
                    byte_cnt_n = '0;
                    poll_cnt_n = '0;
                    tmo_n      = 1'b0;
                    state_n    = LOAD;
                end
            end
            LOAD: begin
                if (byte_cnt < NPIX) begin
                    pix_ready = 1'b1;
                    if (pix_valid) begin
                        shreg_n = pix_data;
                        arm     = 1'b1;
                        state_n = SHIFT;
                    end
                end else begin
                    shreg_n = {4'b0000, label_q};
                    arm     = 1'b1;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (byte_end) begin
                    byte_cnt_n = byte_cnt + 1'b1;
                    if (byte_cnt < NPIX) begin
                        state_n = LOAD;
                    end else begin
                        ss_n      = 1'b1;
                        gap_cnt_n = GAP_LOAD;
                        state_n   = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt != '0) begin
                    gap_cnt_n = gap_cnt - 1'b1;
                end else begin
                    ss_n    = 1'b0;
                    shreg_n = 8'h00;
                    arm     = 1'b1;
                    state_n = POLL;
                end
            end
            POLL: begin
                if (byte_end) begin
                    if (rx[7]) begin
                        digit_n = rx[3:0];
                        shreg_n = 8'h00;
                        arm     = 1'b1;
                        state_n = COST;
                    end else begin
                        poll_cnt_n = poll_inc;
                        ss_n       = 1'b1;
                        if (poll_inc == POLL_LIMIT) begin
                            tmo_n   = 1'b1;
                            state_n = DONE;
                        end else begin
                            gap_cnt_n = GAP_LOAD;
                            state_n   = GAP;
                        end
                    end
                end
            end
            COST: begin
                if (byte_end) begin
                    cost_n  = rx;
                    ss_n    = 1'b1;
                    tmo_n   = 1'b0;
                    state_n = DONE;
                end
            end
            DONE: begin
                result_valid = !tmo_q;
                timeout      = tmo_q;
                state_n      = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // A freshly loaded byte always starts at bit 7 with SCK low.
        if (arm) begin
            bit_cnt_n = 3'd7;
            div_cnt_n = DIV_LOAD;
            sck_n     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state    <= IDLE;
            byte_cnt <= '0;
            poll_cnt <= '0;
            gap_cnt  <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            sck_q    <= 1'b0;
            ss_q     <= 1'b1;
            shreg    <= '0;
            rx       <= '0;
            label_q  <= '0;
            digit_q  <= '0;
            cost_q   <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state    <= state_n;
            byte_cnt <= byte_cnt_n;
            poll_cnt <= poll_cnt_n;
            gap_cnt  <= gap_cnt_n;
            div_cnt  <= div_cnt_n;
            bit_cnt  <= bit_cnt_n;
            sck_q    <= sck_n;
            ss_q     <= ss_n;
            shreg    <= shreg_n;
            rx       <= rx_n;
            label_q  <= label_n;
            digit_q  <= digit_n;
            cost_q   <= cost_n;
            tmo_q    <= tmo_n;
        end
    end

    assign SCK            = sck_q;
    assign SS             = ss_q;
    assign MOSI           = shift_active & shreg[7];
    assign busy           = (state != IDLE);
    assign detected_digit = digit_q;
    assign cost           = cost_q;

endmodule

// File: tb/tb_image_spi_master.sv
// Directed bench for image_spi_master with a small SPI slave model.
module tb_image_spi_master;

    localparam int CLK_DIV    = 2;
    localparam int NUM_PIXELS = 4;
    localparam int GAP_CYCLES = 6;
    localparam int MAX_POLLS  = 3;
    localparam int PERIOD     = 10;
    // first SCK rise to eighth SCK rise of one byte
    localparam int SPAN       = 7 * 2 * CLK_DIV * PERIOD;
    localparam int LIMIT      = 3000;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       start;
    logic [3:0] label;
    logic [7:0] pix_data;
    logic       pix_valid;
    logic       pix_ready;
    logic       SCK, SS, MOSI, MISO;
    logic       busy, result_valid, timeout;
    logic [3:0] detected_digit;
    logic [7:0] cost;

    int checks   = 0;
    int failures = 0;

    image_spi_master #(
        .CLK_DIV(CLK_DIV), .NUM_PIXELS(NUM_PIXELS),
        .GAP_CYCLES(GAP_CYCLES), .MAX_POLLS(MAX_POLLS)
    ) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .label(label),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .SCK(SCK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
        .busy(busy), .result_valid(result_valid),
        .detected_digit(detected_digit), .cost(cost), .timeout(timeout)
    );

    always #(PERIOD / 2) clk = ~clk;

    // ---------------- slave model ----------------
    logic       slave_arm = 1'b0;
    logic [7:0] resp_arr [0:15];
    logic [7:0] tx_byte = 8'h00;
    logic [2:0] tx_idx  = 3'd7;
    int         resp_ptr = 0;

    assign MISO = tx_byte[tx_idx];

    always @(negedge SCK or posedge slave_arm) begin
        if (slave_arm) begin
            resp_ptr = 0;
            tx_byte  = resp_arr[0];
            tx_idx   = 3'd7;
        end else if (tx_idx == 3'd0) begin
            if (resp_ptr < 15) resp_ptr = resp_ptr + 1;
            tx_byte = resp_arr[resp_ptr];
            tx_idx  = 3'd7;
        end else begin
            tx_idx = tx_idx - 3'd1;
        end
    end

    logic [7:0] mon_sr = 8'h00;
    int         mon_bits = 0;
    int         mon_nbytes = 0;
    time        mon_t0 = 0;
    logic [7:0] mon_bytes [0:15];
    int         mon_span  [0:15];

    always @(posedge SCK or posedge slave_arm) begin
        if (slave_arm) begin
            mon_bits   = 0;
            mon_nbytes = 0;
            mon_sr     = 8'h00;
        end else begin
            if (mon_bits == 0) mon_t0 = $time;
            mon_sr = {mon_sr[6:0], MOSI};
            mon_bits++;
            if (mon_bits == 8) begin
                if (mon_nbytes < 16) begin
                    mon_bytes[mon_nbytes] = mon_sr;
                    mon_span[mon_nbytes]  = int'($time - mon_t0);
                end
                mon_nbytes++;
                mon_bits = 0;
            end
        end
    end

    // SS-high runs while busy, result/timeout pulses, SCK-high-with-SS-high
    int mon_hi_run = 0;
    int mon_gcnt = 0;
    int mon_gaps [0:15];
    int mon_rv = 0;
    int mon_to = 0;
    int mon_ss_sck = 0;

    always @(negedge clk) begin
        if (slave_arm) begin
            mon_hi_run = 0; mon_gcnt = 0; mon_rv = 0; mon_to = 0; mon_ss_sck = 0;
        end else begin
            if (SS && busy) begin
                mon_hi_run++;
            end else if (mon_hi_run != 0) begin
                if (mon_gcnt < 16) mon_gaps[mon_gcnt] = mon_hi_run;
                mon_gcnt++;
                mon_hi_run = 0;
            end
            if (result_valid) mon_rv++;
            if (timeout) mon_to++;
            if (SS && SCK) mon_ss_sck++;
        end
    end

    // ---------------- helpers ----------------
    logic [7:0] exp_bytes [0:15];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic arm_slave();
        slave_arm = 1'b1;
        @(negedge clk);
        #1 slave_arm = 1'b0;
    endtask

    task automatic pulse_start(input logic [3:0] l);
        @(negedge clk);
        start = 1'b1;
        label = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_pixel(input logic [7:0] d);
        int n = 0;
        pix_data  = d;
        pix_valid = 1'b1;
        while (!pix_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("pix_accept", int'(n < LIMIT), 1);
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int n = 0;
        while (!(result_valid || timeout) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_end_seen"}, int'(n < LIMIT), 1);
    endtask

    task automatic check_mosi(input string tag, input int n);
        chk({tag, "_byte_count"}, mon_nbytes, n);
        for (int i = 0; i < n && i < 16; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), int'(mon_bytes[i]), int'(exp_bytes[i]));
            chk($sformatf("%s_span%0d", tag, i), mon_span[i], SPAN);
        end
    endtask

    // npolls gaps of GAP_CYCLES, then the single DONE cycle with SS high
    task automatic check_gaps(input string tag, input int npolls);
        chk({tag, "_gap_count"}, mon_gcnt, npolls + 1);
        for (int i = 0; i <= npolls && i < 16; i++) begin
            chk($sformatf("%s_gap%0d", tag, i), mon_gaps[i], (i < npolls) ? GAP_CYCLES : 1);
        end
        chk({tag, "_ss_sck"}, mon_ss_sck, 0);
    endtask

    task automatic set_resp(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        for (int i = 0; i < 16; i++) resp_arr[i] = 8'h00;
        resp_arr[5] = a;
        resp_arr[6] = b;
        resp_arr[7] = c;
        resp_arr[8] = d;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int rises;
        int stall_bad;
        logic sck_prev;

        n_rst = 1'b0; start = 1'b0; label = 4'd0;
        pix_data = 8'h00; pix_valid = 1'b0;
        set_resp(8'h00, 8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);

        chk("rst_ss", int'(SS), 1);
        chk("rst_sck", int'(SCK), 0);
        chk("rst_mosi", int'(MOSI), 0);
        chk("rst_pix_ready", int'(pix_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rv", int'(result_valid), 0);
        chk("rst_timeout", int'(timeout), 0);
        chk("rst_digit", int'(detected_digit), 0);
        chk("rst_cost", int'(cost), 0);
        n_rst = 1'b1;
        @(negedge clk);

        // T1: four pixels + label 7, status 0x85, cost 0x2A
        set_resp(8'h85, 8'h2A, 8'h00, 8'h00);
        arm_slave();
        pulse_start(4'd7);
        chk("t1_busy_on_start", int'(busy), 1);
        chk("t1_ss_on_start", int'(SS), 0);
        push_pixel(8'h81);
        push_pixel(8'h00);
        push_pixel(8'hFF);
        push_pixel(8'h3C);
        wait_end("t1");
        chk("t1_rv", int'(result_valid), 1);
        chk("t1_timeout", int'(timeout), 0);
        chk("t1_digit", int'(detected_digit), 5);
        chk("t1_cost", int'(cost), 8'h2A);
        chk("t1_busy_done", int'(busy), 1);
        @(negedge clk);
        chk("t1_busy_drop", int'(busy), 0);
        @(negedge clk);
        exp_bytes[0] = 8'h81; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'hFF;
        exp_bytes[3] = 8'h3C; exp_bytes[4] = 8'h07; exp_bytes[5] = 8'h00;
        exp_bytes[6] = 8'h00;
        check_mosi("t1", 7);
        check_gaps("t1", 1);
        chk("t1_rv_pulses", mon_rv, 1);
        chk("t1_to_pulses", mon_to, 0);

        // T2: stall before byte 2, ignored start, status 00,00,83 then cost 5C
        set_resp(8'h00, 8'h00, 8'h83, 8'h5C);
        arm_slave();
        pulse_start(4'd9);
        push_pixel(8'h12);
        n = 0;
        while (!pix_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("t2_reload_ready", int'(n < LIMIT), 1);
        stall_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (SCK !== 1'b0 || SS !== 1'b0 || pix_ready !== 1'b1) stall_bad++;
            if (i == 4) begin start = 1'b1; label = 4'd4; end
            if (i == 5) start = 1'b0;
            @(negedge clk);
        end
        chk("t2_stall_hold", stall_bad, 0);
        push_pixel(8'h34);
        push_pixel(8'h56);
        push_pixel(8'h78);
        wait_end("t2");
        chk("t2_rv", int'(result_valid), 1);
        chk("t2_digit", int'(detected_digit), 3);
        chk("t2_cost", int'(cost), 8'h5C);
        @(negedge clk);
        chk("t2_busy_drop", int'(busy), 0);
        @(negedge clk);
        exp_bytes[0] = 8'h12; exp_bytes[1] = 8'h34; exp_bytes[2] = 8'h56;
        exp_bytes[3] = 8'h78; exp_bytes[4] = 8'h09; exp_bytes[5] = 8'h00;
        exp_bytes[6] = 8'h00; exp_bytes[7] = 8'h00; exp_bytes[8] = 8'h00;
        check_mosi("t2", 9);
        check_gaps("t2", 3);
        chk("t2_rv_pulses", mon_rv, 1);

        // T3: status never ready -> timeout after MAX_POLLS, results kept
        set_resp(8'h00, 8'h00, 8'h00, 8'h00);
        arm_slave();
        pulse_start(4'd1);
        push_pixel(8'h01);
        push_pixel(8'h02);
        push_pixel(8'h03);
        push_pixel(8'h04);
        wait_end("t3");
        chk("t3_timeout", int'(timeout), 1);
        chk("t3_rv", int'(result_valid), 0);
        chk("t3_digit_kept", int'(detected_digit), 3);
        chk("t3_cost_kept", int'(cost), 8'h5C);
        @(negedge clk);
        chk("t3_busy_drop", int'(busy), 0);
        @(negedge clk);
        exp_bytes[0] = 8'h01; exp_bytes[1] = 8'h02; exp_bytes[2] = 8'h03;
        exp_bytes[3] = 8'h04; exp_bytes[4] = 8'h01; exp_bytes[5] = 8'h00;
        exp_bytes[6] = 8'h00; exp_bytes[7] = 8'h00;
        check_mosi("t3", 8);
        check_gaps("t3", 3);
        chk("t3_rv_pulses", mon_rv, 0);
        chk("t3_to_pulses", mon_to, 1);

        // T4: reset during bit 3 of the second pixel byte, then a clean restart
        arm_slave();
        pulse_start(4'd6);
        push_pixel(8'h11);
        push_pixel(8'h22);
        rises = 0;
        sck_prev = SCK;
        n = 0;
        while (!(rises == 2 && !SCK) && n < LIMIT) begin
            @(negedge clk);
            if (SCK && !sck_prev) rises++;
            sck_prev = SCK;
            n++;
        end
        chk("t4_reach_bit3", int'(n < LIMIT), 1);
        n_rst = 1'b0;
        @(negedge clk);
        chk("t4_rst_ss", int'(SS), 1);
        chk("t4_rst_sck", int'(SCK), 0);
        chk("t4_rst_busy", int'(busy), 0);
        chk("t4_rst_mosi", int'(MOSI), 0);
        chk("t4_rst_pix_ready", int'(pix_ready), 0);
        chk("t4_rst_digit", int'(detected_digit), 0);
        chk("t4_rst_cost", int'(cost), 0);
        n_rst = 1'b1;
        @(negedge clk);
        set_resp(8'h81, 8'h11, 8'h00, 8'h00);
        arm_slave();
        pulse_start(4'd2);
        push_pixel(8'hA1);
        push_pixel(8'hB2);
        push_pixel(8'hC3);
        push_pixel(8'hD4);
        wait_end("t4");
        chk("t4_rv", int'(result_valid), 1);
        chk("t4_digit", int'(detected_digit), 1);
        chk("t4_cost", int'(cost), 8'h11);
        repeat (2) @(negedge clk);
        exp_bytes[0] = 8'hA1; exp_bytes[1] = 8'hB2; exp_bytes[2] = 8'hC3;
        exp_bytes[3] = 8'hD4; exp_bytes[4] = 8'h02; exp_bytes[5] = 8'h00;
        exp_bytes[6] = 8'h00;
        check_mosi("t4", 7);
        check_gaps("t4", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
